fmap_stream_sequencer: RTL and testbench

FMAP_STREAM_SEQUENCER -- requirements
Module: fmap_stream_sequencer

---
 rtl/fmap_stream_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_fmap_stream_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_sequencer.sv
// Feature-map stream sequencer: forwards one frame of source pixels to the line
// buffer, appends the bottom zero-padding rows, then waits for the window count.
// Latency: one registered cycle from an accepted pixel to buf_valid/buf_data.
// Backpressure: src_ready is high only in STREAM; there is no backpressure from
// the line buffer side.
// Ports:
//   clk, rstn          clock and synchronous active-low reset
//   start, abort       frame start pulse (IDLE only), synchronous frame abort
//   src_valid/ready    source pixel handshake, src_data carries the pixel word
//   buf_valid/data     pixel strobe and word towards the line buffer
//   win_ready          window-produced strobe from the line buffer
//   win_cnt            windows received in the current frame (saturating)
//   busy, frame_done   not-IDLE status and one-cycle completion pulse
//   drain_err          sticky flag: windows did not arrive within DRAIN_MAX cycles
module fmap_stream_sequencer #(
  parameter int NW        = 32,
  parameter int NH        = 32,
  parameter int KER_SIZE  = 3,
  parameter int PAD       = 1,
  parameter int STRIDE    = 1,
  parameter int DW        = 24,
  parameter int DRAIN_MAX = 256,
  localparam int OW       = (NW + 2 * PAD - KER_SIZE) / STRIDE + 1,
  localparam int OH       = (NH + 2 * PAD - KER_SIZE) / STRIDE + 1,
  localparam int NWIN     = OH * OW,
  localparam int WCW      = $clog2(NWIN + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           abort,
  input  logic           src_valid,
  input  logic [DW-1:0]  src_data,
  output logic           src_ready,
  output logic           buf_valid,
  output logic [DW-1:0]  buf_data,
  input  logic           win_ready,
  output logic [WCW-1:0] win_cnt,
  output logic           busy,
  output logic           frame_done,
  output logic           drain_err
);

  localparam int CW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW   = $clog2(NH + 1);
  localparam int PADN = PAD * NW;
  localparam int PCW  = (PADN > 1) ? $clog2(PADN) : 1;
  localparam int DCW  = $clog2(DRAIN_MAX + 1);

  if (OW < 1 || OH < 1) begin : g_bad_geometry
    $error("fmap_stream_sequencer: output frame is empty (OW=%0d OH=%0d)", OW, OH);
  end
  if (KER_SIZE != 2 && KER_SIZE != 3 && KER_SIZE != 5 && KER_SIZE != 7) begin : g_bad_kernel
    $error("fmap_stream_sequencer: KER_SIZE=%0d is not one of 2, 3, 5, 7", KER_SIZE);
  end
  if (DRAIN_MAX < 1) begin : g_bad_drain
    $error("fmap_stream_sequencer: DRAIN_MAX must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_PAD_BOTTOM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [PCW-1:0] pad_cnt;
  logic [DCW-1:0] drain_cnt;

  logic           accept;
  logic           last_px;
  logic           pad_last;
  logic           drain_last;
  logic           win_inc;
  logic [WCW-1:0] win_cnt_sum;
  logic           start_frame;
  logic           drain_to;

  assign src_ready  = (state == S_STREAM);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  assign accept     = src_valid && src_ready;
  assign last_px    = (row == RW'(NH - 1)) && (col == CW'(NW - 1));
  assign pad_last   = (pad_cnt == PCW'(PADN - 1));
  assign drain_last = (drain_cnt == DCW'(DRAIN_MAX - 1));

  // Window count saturates at the frame total; the sum is what DRAIN tests so
  // a window arriving in the same cycle completes the frame immediately.
  assign win_inc     = busy && win_ready && (win_cnt != WCW'(NWIN));
  assign win_cnt_sum = win_cnt + WCW'(win_inc);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    drain_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt   = S_STREAM;
          start_frame = 1'b1;
        end
      end
      S_STREAM: begin
        if (accept && last_px) begin
          state_nxt = (PAD > 0) ? S_PAD_BOTTOM : S_DRAIN;
        end
      end
      S_PAD_BOTTOM: begin
        if (pad_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (win_cnt_sum == WCW'(NWIN)) begin
          state_nxt = S_DONE;
        end else if (drain_last) begin
          state_nxt = S_DONE;
          drain_to  = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt   = S_IDLE;
      start_frame = 1'b0;
      drain_to    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      col       <= '0;
      row       <= '0;
      pad_cnt   <= '0;
      drain_cnt <= '0;
      win_cnt   <= '0;
      drain_err <= 1'b0;
    end else begin
      // Pixel path: registered copy of the accepted pixel, or zeros while
      // emitting bottom padding; data holds when nothing is emitted.
      buf_valid <= 1'b0;
      if (!abort) begin
        if (accept) begin
          buf_valid <= 1'b1;
          buf_data  <= src_data;
        end else if (state == S_PAD_BOTTOM) begin
          buf_valid <= 1'b1;
          buf_data  <= '0;
        end
      end

      if (start_frame) begin
        col       <= '0;
        row       <= '0;
        pad_cnt   <= '0;
        drain_cnt <= '0;
        win_cnt   <= '0;
        drain_err <= 1'b0;
      end else begin
        if (accept && !abort) begin
          if (col == CW'(NW - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (state == S_PAD_BOTTOM) begin
          pad_cnt <= pad_last ? '0 : pad_cnt + 1'b1;
        end
        if (state == S_DRAIN) begin
          drain_cnt <= drain_cnt + 1'b1;
        end
        if (win_inc) begin
          win_cnt <= win_cnt + 1'b1;
        end
        if (drain_to) begin
          drain_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fmap_stream_sequencer.sv
// Bench for fmap_stream_sequencer: two instances (4x4 frame, 3x3 kernel, pad 1)
// with stride 1 / DRAIN_MAX 16 and stride 2 / DRAIN_MAX 8 share all inputs.
// Frame scenarios come from a vector table; abort, ignored start and reset in
// PAD_BOTTOM are hand-written sequences. Pixel data goes through a scoreboard.
module tb_fmap_stream_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic        src_valid;
  logic [23:0] src_data;
  logic        win_ready;

  logic        src_ready, buf_valid, busy, frame_done, drain_err;
  logic [23:0] buf_data;
  logic [4:0]  win_cnt;

  logic        s2_src_ready, s2_buf_valid, s2_busy, s2_frame_done, s2_drain_err;
  logic [23:0] s2_buf_data;
  logic [2:0]  s2_win_cnt;

  always #5 clk = ~clk;

  fmap_stream_sequencer #(
    .NW(4), .NH(4), .KER_SIZE(3), .PAD(1), .STRIDE(1), .DW(24), .DRAIN_MAX(16)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .buf_valid(buf_valid), .buf_data(buf_data), .win_ready(win_ready),
    .win_cnt(win_cnt), .busy(busy), .frame_done(frame_done), .drain_err(drain_err)
  );

  fmap_stream_sequencer #(
    .NW(4), .NH(4), .KER_SIZE(3), .PAD(1), .STRIDE(2), .DW(24), .DRAIN_MAX(8)
  ) u_dut_s2 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(s2_src_ready),
    .buf_valid(s2_buf_valid), .buf_data(s2_buf_data), .win_ready(win_ready),
    .win_cnt(s2_win_cnt), .busy(s2_busy), .frame_done(s2_frame_done),
    .drain_err(s2_drain_err)
  );

  typedef struct {
    bit gap;         // idle cycle before every pixel
    int early;       // win_ready on the first 'early' pixel cycles
    int wlo;         // win_ready window after the last pixel (cycle index c1..)
    int whi;
    int done_at;     // cycle index at which frame_done is seen
    bit err;
    int wcnt;
    int s2_done_at;
    bit s2_err;
    int s2_wcnt;
  } frame_vec_t;

  frame_vec_t  fv [7];
  int          n_vec = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  int          s2_fd_cnt = 0;
  int          d_at, s2_d_at;
  logic [23:0] exp_q [$];
  logic [23:0] sb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and pulse counters sample mid-cycle, away from the driver.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (s2_frame_done === 1'b1) s2_fd_cnt++;
    if (buf_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: buf_valid with data %0h, nothing expected", buf_data);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_buf_data", 32'(buf_data), 32'(sb_exp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input bit gap, input int early, input int start_at, input int n_pix);
    for (int p = 0; p < n_pix; p++) begin
      if (gap) begin
        src_valid = 1'b0;
        win_ready = 1'b0;
        tick();
        chk("gap_buf_valid", 32'(buf_valid), 0);
      end
      src_valid = 1'b1;
      src_data  = 24'($urandom);
      win_ready = (p < early);
      start     = (p == start_at);
      chk("src_ready", 32'(src_ready), 1);
      exp_q.push_back(src_data);
      if (p == 15) begin
        for (int z = 0; z < 4; z++) exp_q.push_back(24'h0);
      end
      tick();
      chk("stream_buf_valid", 32'(buf_valid), 1);
    end
    src_valid = 1'b0;
    win_ready = 1'b0;
    start     = 1'b0;
  endtask

  // Fixed 30-cycle tail after the last pixel; records when frame_done shows.
  task automatic tail(input int wlo, input int whi, output int done_at, output int s2_done_at);
    done_at    = 0;
    s2_done_at = 0;
    for (int k = 1; k <= 30; k++) begin
      win_ready = (k >= wlo && k <= whi);
      tick();
      chk("tail_buf_valid", 32'(buf_valid), 32'(k <= 4));
      if (frame_done && done_at == 0) done_at = k + 1;
      if (s2_frame_done && s2_done_at == 0) s2_done_at = k + 1;
    end
    win_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    //          gap   early wlo whi done err   wcnt s2d s2err s2w
    fv[0] = '{1'b0,  0,   1, 16, 17, 1'b0, 16,  6, 1'b0, 4};  // back-to-back, late windows
    fv[1] = '{1'b1,  0,   1, 16, 17, 1'b0, 16,  6, 1'b0, 4};  // src_valid toggling
    fv[2] = '{1'b0, 16,   1,  0,  6, 1'b0, 16,  6, 1'b0, 4};  // all windows before DRAIN
    fv[3] = '{1'b0, 10,   1,  0, 21, 1'b1, 10,  6, 1'b0, 4};  // main drain timeout
    fv[4] = '{1'b0, 16,   1,  4,  6, 1'b0, 16,  6, 1'b0, 4};  // saturation, err cleared
    fv[5] = '{1'b0,  0,   5,  8, 21, 1'b1,  4,  9, 1'b0, 4};  // stride 2 done after 4th
    fv[6] = '{1'b0,  0,   1,  0, 21, 1'b1,  0, 13, 1'b1, 0};  // no windows at all

    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    src_valid = 1'b0; src_data = 24'h0; win_ready = 1'b0;
    repeat (3) tick();
    chk("rst_src_ready", 32'(src_ready), 0);
    chk("rst_buf_valid", 32'(buf_valid), 0);
    chk("rst_buf_data", 32'(buf_data), 0);
    chk("rst_win_cnt", 32'(win_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_drain_err", 32'(drain_err), 0);
    chk("rst_s2_busy", 32'(s2_busy), 0);
    rstn = 1'b1;
    tick();

    for (int r = 0; r < 7; r++) begin
      fd_cnt = 0;
      s2_fd_cnt = 0;
      do_start();
      chk("start_busy", 32'(busy), 1);
      chk("start_win_cnt", 32'(win_cnt), 0);
      chk("start_drain_err", 32'(drain_err), 0);
      chk("start_s2_busy", 32'(s2_busy), 1);
      stream(fv[r].gap, fv[r].early, -1, 16);
      chk("pad_src_ready", 32'(src_ready), 0);
      tail(fv[r].wlo, fv[r].whi, d_at, s2_d_at);
      chk("frame_done_at", 32'(d_at), 32'(fv[r].done_at));
      chk("frame_done_cnt", 32'(fd_cnt), 1);
      chk("frame_drain_err", 32'(drain_err), 32'(fv[r].err));
      chk("frame_win_cnt", 32'(win_cnt), 32'(fv[r].wcnt));
      chk("frame_idle", 32'(busy), 0);
      chk("s2_done_at", 32'(s2_d_at), 32'(fv[r].s2_done_at));
      chk("s2_done_cnt", 32'(s2_fd_cnt), 1);
      chk("s2_drain_err", 32'(s2_drain_err), 32'(fv[r].s2_err));
      chk("s2_win_cnt", 32'(s2_win_cnt), 32'(fv[r].s2_wcnt));
      chk("s2_idle", 32'(s2_busy), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);
    end

    // Abort while pixel 7 is offered, with three windows already counted.
    fd_cnt = 0;
    do_start();
    stream(1'b0, 3, -1, 7);
    abort = 1'b1; src_valid = 1'b1; src_data = 24'hABCDEF;
    tick();
    abort = 1'b0; src_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_src_ready", 32'(src_ready), 0);
    chk("abort_buf_valid", 32'(buf_valid), 0);
    chk("abort_win_cnt", 32'(win_cnt), 3);
    repeat (5) tick();
    chk("abort_no_done", 32'(fd_cnt), 0);
    chk("abort_stays_idle", 32'(busy), 0);
    chk("abort_sb_empty", 32'(exp_q.size()), 0);
    do_start();
    chk("restart_win_cnt", 32'(win_cnt), 0);
    chk("restart_busy", 32'(busy), 1);

    // Start pulse mid-stream is ignored; then reset lands in PAD_BOTTOM.
    stream(1'b0, 5, 5, 16);
    chk("ign_busy", 32'(busy), 1);
    chk("ign_src_ready", 32'(src_ready), 0);
    chk("ign_win_cnt", 32'(win_cnt), 5);
    rstn = 1'b0;
    tick();
    exp_q.delete();
    chk("padrst_src_ready", 32'(src_ready), 0);
    chk("padrst_buf_valid", 32'(buf_valid), 0);
    chk("padrst_buf_data", 32'(buf_data), 0);
    chk("padrst_win_cnt", 32'(win_cnt), 0);
    chk("padrst_busy", 32'(busy), 0);
    chk("padrst_frame_done", 32'(frame_done), 0);
    chk("padrst_drain_err", 32'(drain_err), 0);
    chk("padrst_s2_busy", 32'(s2_busy), 0);
    rstn = 1'b1;
    fd_cnt = 0;
    repeat (10) tick();
    chk("postrst_idle", 32'(busy), 0);
    chk("postrst_no_done", 32'(fd_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
